fractal_sync_1d_req_tx: RTL and testbench
=========================================

// Module: fractal_sync_1d_req_tx
// PURPOSE
//  Initiator side of the 1D fractal-sync barrier protocol; one instance per core port, feeding a sync node/remote RF port.
//  Accepts barrier requests (level, id) from the core and checks their signature. Issues each valid request on the sync channel.
//  Tracks outstanding barriers until the matching wake returns, then reports completion or error on a single response channel.
// PARAMETERS
//  LEVEL_WIDTH    1  bits of barrier level
//  ID_WIDTH       1  bits of barrier id
//  N_OUTSTANDING  4  outstanding-barrier table entries (>=1)
//  TIMEOUT_CYCLES 0  cycles SENT->wake before timeout error; 0 disables timeout logic
// PORTS
//  clk_i         in   1            clock
//  rst_i         in   1            reset, synchronous, active-high
//  req_valid_i   in   1            core barrier request valid
//  req_ready_o   out  1            request accepted when valid&ready
//  req_level_i   in   LEVEL_WIDTH  requested level
//  req_id_i      in   ID_WIDTH     requested id
//  sync_valid_o  out  1            sync request to network
//  sync_ready_i  in   1            network accepts sync request
//  sync_level_o  out  LEVEL_WIDTH  level of issued request
//  sync_id_o     out  ID_WIDTH     id of issued request
//  wake_valid_i  in   1            wake/response from network (no backpressure)
//  wake_level_i  in   LEVEL_WIDTH  wake level
//  wake_id_i     in   ID_WIDTH     wake id
//  wake_err_i    in   1            network flagged error for this barrier
//  resp_valid_o  out  1            one-cycle response pulse to core
//  resp_level_o  out  LEVEL_WIDTH  level of responded barrier
//  resp_id_o     out  ID_WIDTH     id of responded barrier
//  resp_code_o   out  3            fs_resp_e: OK, SIG_ERR, DUP_ERR, NET_ERR, UNEXP, TIMEOUT
// BEHAVIOUR
//  Reset: table empty, sync_valid_o=0, resp_valid_o=0, sync/resp data=0, timers=0.
//  Entry states: FREE -> PEND (accepted, awaiting sync handshake) -> SENT (handshaken) -> FREE (wake/timeout).
//  req_ready_o = (>=1 FREE entry) & ~wake_valid_i & ~(sync_valid_o & ~sync_ready_i); responses never collide.
//  Signature: sig = LVL_SIG_LOOKUP[level] + id[ID_WIDTH-1:1]; legal iff sig < LVL_SIG_LOOKUP[level+1]
//   and sig <= N_DM_REGS-1, N_DM_REGS=(2**(ID_WIDTH+2)-2)/3. Width MAX_LOOKUP_LVL_WIDTH, no truncation.
//  Accept at cycle t:
//   illegal sig                -> resp SIG_ERR at t+1, no entry, nothing sent.
//   (level,id) in PEND/SENT    -> resp DUP_ERR at t+1, no entry.
//   else                       -> lowest FREE entry becomes PEND; sync_valid_o=1 with data from t+1.
//  sync_valid_o/data stable until sync_ready_i; on handshake entry PEND->SENT, same cycle as a new accept allowed only
//   if handshake frees the stage (ready term above). One PEND entry max; issue order = accept order.
//  Wake at cycle t: match against SENT entries on (level,id) -> entry FREE, resp at t+1 with code OK or NET_ERR (wake_err_i).
//   No SENT match (incl. PEND match) -> resp UNEXP at t+1, table unchanged.
//  Timeout (TIMEOUT_CYCLES>0): per-entry counter clears on ->SENT, increments while SENT; reaching TIMEOUT_CYCLES
//   frees entry, resp TIMEOUT next cycle only if no wake resp pending that cycle, else deferred one cycle (counter holds).
//  Wake matching an entry in the same cycle its timeout fires: wake wins, timeout dropped.
//  Full table: req_ready_o=0; wake freeing an entry at t allows accept at t+1.
//  Reset mid-operation: all entries FREE, sync_valid_o drops next edge, in-flight responses discarded.
// STRUCTURE
//  fractal_sync_pkg: LVL_SIG_LOOKUP, MAX_LVL_WIDTH, fs_resp_e, fs_entry_state_e, sig-legality function shared with RF.
//  Sub-module fractal_sync_sig_check (comb: level,id -> sig, sig_valid), also reusable by the remote RF.
//  Top: entry table + lowest-free priority encoder, single output stage register, response register, timers.
// TESTING
//  L=1,id=2 accept, sync_ready_i=1 -> sync_valid_o t+1; wake(1,2) -> resp OK (1,2) next cycle, table empty.
//  Illegal (level,id) (sig>=LVL_SIG_LOOKUP[level+1]) -> resp SIG_ERR t+1, sync_valid_o stays 0.
//  Fill N_OUTSTANDING=4 distinct, then 5th -> req_ready_o=0; one wake -> accept next cycle; repeat id -> DUP_ERR.
//  sync_ready_i low 5 cycles -> sync data stable, req_ready_o=0; wake for that PEND barrier -> UNEXP.
//  TIMEOUT_CYCLES=8, no wake -> TIMEOUT resp 8 cycles after handshake; wake at same cycle -> OK only.
//  rst_i asserted with 3 SENT entries and sync pending -> all outputs 0 next cycle; later wakes -> UNEXP.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// Shared definitions for the 1D fractal-sync barrier blocks: signature
// lookup table, response codes, table-entry states and the legality rule.
package fractal_sync_pkg;

    localparam int MAX_LVL_WIDTH = 32;
    localparam int MAX_LEVELS    = 16;

    // First signature slot of each level; level k owns 2**k consecutive slots.
    // The extra last entry bounds the top level. Supports LEVEL_WIDTH <= 4.
    localparam logic [MAX_LVL_WIDTH-1:0] LVL_SIG_LOOKUP [0:MAX_LEVELS] = '{
        32'd0,    32'd1,    32'd3,    32'd7,    32'd15,   32'd31,
        32'd63,   32'd127,  32'd255,  32'd511,  32'd1023, 32'd2047,
        32'd4095, 32'd8191, 32'd16383, 32'd32767, 32'd65535
    };

    typedef enum logic [2:0] {
        FS_OK      = 3'd0,
        FS_SIG_ERR = 3'd1,
        FS_DUP_ERR = 3'd2,
        FS_NET_ERR = 3'd3,
        FS_UNEXP   = 3'd4,
        FS_TIMEOUT = 3'd5
    } fs_resp_e;

    typedef enum logic [1:0] {
        FS_FREE = 2'd0,
        FS_PEND = 2'd1,
        FS_SENT = 2'd2
    } fs_entry_state_e;

    // Number of DM registers addressable by a given id width.
    function automatic logic [MAX_LVL_WIDTH-1:0] fs_n_dm_regs(input int id_width);
        return MAX_LVL_WIDTH'(((2 ** (id_width + 2)) - 2) / 3);
    endfunction

    // A signature is legal when it stays inside its level and inside the DM space.
    function automatic logic fs_sig_legal(input logic [MAX_LVL_WIDTH-1:0] sig,
                                          input logic [MAX_LVL_WIDTH-1:0] lvl_limit,
                                          input logic [MAX_LVL_WIDTH-1:0] n_dm_regs);
        return (sig < lvl_limit) && (sig <= n_dm_regs - 1);
    endfunction

endpackage

// File: rtl/fractal_sync_sig_check.sv
// Combinational barrier signature check: (level, id) -> legal / illegal.
// The signature is kept at full lookup width so no carry is lost.
module fractal_sync_sig_check
    import fractal_sync_pkg::*;
#(
    parameter int LEVEL_WIDTH = 1,
    parameter int ID_WIDTH    = 1
) (
    input  logic [LEVEL_WIDTH-1:0] level,
    input  logic [ID_WIDTH-1:0]    id,
    output logic                   sig_valid
);

    localparam logic [MAX_LVL_WIDTH-1:0] N_DM_REGS = fs_n_dm_regs(ID_WIDTH);

    logic [4:0]               lvl_idx;
    logic [MAX_LVL_WIDTH-1:0] sig;

    // Signature = level base slot + id without its lowest bit
    always_comb begin
        lvl_idx   = 5'(level);
        sig       = LVL_SIG_LOOKUP[lvl_idx] + MAX_LVL_WIDTH'(id >> 1);
        sig_valid = fs_sig_legal(sig, LVL_SIG_LOOKUP[lvl_idx + 5'd1], N_DM_REGS);
    end

endmodule

// File: rtl/fractal_sync_1d_req_tx.sv
// Initiator side of the 1D fractal-sync barrier protocol.
// Handshakes: a transfer happens on a cycle where valid & ready are both high;
// a source holds valid and data stable until that cycle. Wakes have no ready.
// A timeout fires on the cycle an entry's timer would reach TIMEOUT_CYCLES,
// i.e. its response is registered on the TIMEOUT_CYCLES-th edge after the
// sync handshake edge; a busy response slot defers it with the timer held.
module fractal_sync_1d_req_tx
    import fractal_sync_pkg::*;
#(
    parameter int LEVEL_WIDTH    = 1,
    parameter int ID_WIDTH       = 1,
    parameter int N_OUTSTANDING  = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic                   sync_valid_o,
    input  logic                   sync_ready_i,
    output logic [LEVEL_WIDTH-1:0] sync_level_o,
    output logic [ID_WIDTH-1:0]    sync_id_o,
    input  logic                   wake_valid_i,
    input  logic [LEVEL_WIDTH-1:0] wake_level_i,
    input  logic [ID_WIDTH-1:0]    wake_id_i,
    input  logic                   wake_err_i,
    output logic                   resp_valid_o,
    output logic [LEVEL_WIDTH-1:0] resp_level_o,
    output logic [ID_WIDTH-1:0]    resp_id_o,
    output logic [2:0]             resp_code_o
);

    localparam int IDX_W = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT =
        TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    // Entry table (entry_st is the per-entry state, visible for checkers)
    fs_entry_state_e        entry_st      [N_OUTSTANDING];
    fs_entry_state_e        entry_st_nxt  [N_OUTSTANDING];
    logic [LEVEL_WIDTH-1:0] entry_lvl     [N_OUTSTANDING];
    logic [LEVEL_WIDTH-1:0] entry_lvl_nxt [N_OUTSTANDING];
    logic [ID_WIDTH-1:0]    entry_id      [N_OUTSTANDING];
    logic [ID_WIDTH-1:0]    entry_id_nxt  [N_OUTSTANDING];
    logic [TMR_W-1:0]       entry_tmr     [N_OUTSTANDING];
    logic [TMR_W-1:0]       entry_tmr_nxt [N_OUTSTANDING];
    logic [IDX_W-1:0]       pend_idx, pend_idx_nxt;

    logic                   sync_valid_nxt;
    logic [LEVEL_WIDTH-1:0] sync_level_nxt;
    logic [ID_WIDTH-1:0]    sync_id_nxt;
    logic                   resp_valid_nxt;
    logic [LEVEL_WIDTH-1:0] resp_level_nxt;
    logic [ID_WIDTH-1:0]    resp_id_nxt;
    fs_resp_e               resp_code_q, resp_code_nxt;

    logic             sig_valid;
    logic             any_free, req_dup, wake_hit, tmo_hit;
    logic [IDX_W-1:0] free_idx, wake_idx, tmo_idx;
    logic             sync_stall, sync_hs, accept, acc_err, tmo_fire;

    fractal_sync_sig_check #(
        .LEVEL_WIDTH (LEVEL_WIDTH),
        .ID_WIDTH    (ID_WIDTH)
    ) u_sig_check (
        .level     (req_level_i),
        .id        (req_id_i),
        .sig_valid (sig_valid)
    );

    // Table scan: lowest free entry, duplicate lookup, SENT wake match, expired timer
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        req_dup  = 1'b0;
        wake_hit = 1'b0;
        wake_idx = '0;
        tmo_hit  = 1'b0;
        tmo_idx  = '0;
        for (int i = N_OUTSTANDING - 1; i >= 0; i--) begin
            if (entry_st[i] == FS_FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (TIMEOUT_CYCLES > 0 && entry_st[i] == FS_SENT && entry_tmr[i] == TMR_LIMIT) begin
                tmo_hit = 1'b1;
                tmo_idx = IDX_W'(i);
            end
            if (entry_st[i] != FS_FREE && entry_lvl[i] == req_level_i && entry_id[i] == req_id_i)
                req_dup = 1'b1;
            if (entry_st[i] == FS_SENT && entry_lvl[i] == wake_level_i && entry_id[i] == wake_id_i) begin
                wake_hit = 1'b1;
                wake_idx = IDX_W'(i);
            end
        end
    end

    // Handshake and response-slot arbitration; a wake always owns the slot,
    // so it beats a timeout of the same entry and defers any other timeout
    always_comb begin
        sync_stall  = sync_valid_o & ~sync_ready_i;
        sync_hs     = sync_valid_o & sync_ready_i;
        req_ready_o = any_free & ~wake_valid_i & ~sync_stall;
        accept      = req_valid_i & req_ready_o;
        acc_err     = accept & (~sig_valid | req_dup);
        tmo_fire    = tmo_hit & ~wake_valid_i & ~acc_err;
        resp_code_o = resp_code_q;
    end

    // Next state of the table, output stage and response register
    always_comb begin
        entry_st_nxt   = entry_st;
        entry_lvl_nxt  = entry_lvl;
        entry_id_nxt   = entry_id;
        entry_tmr_nxt  = entry_tmr;
        pend_idx_nxt   = pend_idx;
        sync_valid_nxt = sync_valid_o;
        sync_level_nxt = sync_level_o;
        sync_id_nxt    = sync_id_o;
        resp_valid_nxt = 1'b0;
        resp_level_nxt = resp_level_o;
        resp_id_nxt    = resp_id_o;
        resp_code_nxt  = resp_code_q;

        if (TIMEOUT_CYCLES > 0) begin
            for (int i = 0; i < N_OUTSTANDING; i++)
                if (entry_st[i] == FS_SENT && entry_tmr[i] != TMR_LIMIT)
                    entry_tmr_nxt[i] = entry_tmr[i] + 1'b1;
        end

        if (sync_hs) begin
            entry_st_nxt[pend_idx]  = FS_SENT;
            entry_tmr_nxt[pend_idx] = '0;
            sync_valid_nxt          = 1'b0;
        end

        if (accept) begin
            if (!sig_valid || req_dup) begin
                resp_valid_nxt = 1'b1;
                resp_level_nxt = req_level_i;
                resp_id_nxt    = req_id_i;
                resp_code_nxt  = !sig_valid ? FS_SIG_ERR : FS_DUP_ERR;
            end else begin
                entry_st_nxt[free_idx]  = FS_PEND;
                entry_lvl_nxt[free_idx] = req_level_i;
                entry_id_nxt[free_idx]  = req_id_i;
                pend_idx_nxt            = free_idx;
                sync_valid_nxt          = 1'b1;
                sync_level_nxt          = req_level_i;
                sync_id_nxt             = req_id_i;
            end
        end

        if (wake_valid_i) begin
            resp_valid_nxt = 1'b1;
            resp_level_nxt = wake_level_i;
            resp_id_nxt    = wake_id_i;
            resp_code_nxt  = !wake_hit ? FS_UNEXP : (wake_err_i ? FS_NET_ERR : FS_OK);
            if (wake_hit)
                entry_st_nxt[wake_idx] = FS_FREE;
        end

        if (tmo_fire) begin
            entry_st_nxt[tmo_idx] = FS_FREE;
            resp_valid_nxt        = 1'b1;
            resp_level_nxt        = entry_lvl[tmo_idx];
            resp_id_nxt           = entry_id[tmo_idx];
            resp_code_nxt         = FS_TIMEOUT;
        end
    end

    // State register; reset empties the table and drops anything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_OUTSTANDING; i++) begin
                entry_st[i]  <= FS_FREE;
                entry_lvl[i] <= '0;
                entry_id[i]  <= '0;
                entry_tmr[i] <= '0;
            end
            pend_idx     <= '0;
            sync_valid_o <= 1'b0;
            sync_level_o <= '0;
            sync_id_o    <= '0;
            resp_valid_o <= 1'b0;
            resp_level_o <= '0;
            resp_id_o    <= '0;
            resp_code_q  <= FS_OK;
        end else begin
            entry_st     <= entry_st_nxt;
            entry_lvl    <= entry_lvl_nxt;
            entry_id     <= entry_id_nxt;
            entry_tmr    <= entry_tmr_nxt;
            pend_idx     <= pend_idx_nxt;
            sync_valid_o <= sync_valid_nxt;
            sync_level_o <= sync_level_nxt;
            sync_id_o    <= sync_id_nxt;
            resp_valid_o <= resp_valid_nxt;
            resp_level_o <= resp_level_nxt;
            resp_id_o    <= resp_id_nxt;
            resp_code_q  <= resp_code_nxt;
        end
    end

endmodule

// File: tb/tb_fractal_sync_1d_req_tx.sv
// Bench for fractal_sync_1d_req_tx: directed scenarios followed by random
// traffic, all checked each cycle against a behavioural barrier-table model.
module tb_fractal_sync_1d_req_tx;
    import fractal_sync_pkg::*;

    localparam int LW  = 2;
    localparam int IW  = 2;
    localparam int NO  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready_o;
    logic [LW-1:0] req_level, sync_level_o, wake_level, resp_level_o;
    logic [IW-1:0] req_id, sync_id_o, wake_id, resp_id_o;
    logic          sync_valid_o, sync_ready;
    logic          wake_valid, wake_err, resp_valid_o;
    logic [2:0]    resp_code_o;

    // Clock
    always #5 clk = ~clk;

    fractal_sync_1d_req_tx #(
        .LEVEL_WIDTH (LW), .ID_WIDTH (IW), .N_OUTSTANDING (NO), .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (req_valid), .req_ready_o (req_ready_o),
        .req_level_i (req_level), .req_id_i (req_id),
        .sync_valid_o (sync_valid_o), .sync_ready_i (sync_ready),
        .sync_level_o (sync_level_o), .sync_id_o (sync_id_o),
        .wake_valid_i (wake_valid), .wake_level_i (wake_level),
        .wake_id_i (wake_id), .wake_err_i (wake_err),
        .resp_valid_o (resp_valid_o), .resp_level_o (resp_level_o),
        .resp_id_o (resp_id_o), .resp_code_o (resp_code_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit last_acc;

    // Reference model: per slot 0=free 1=awaiting sync 2=sent; mh = handshake cycle
    int ms [NO];
    int ml [NO];
    int mi [NO];
    int mh [NO];
    int m_pend;
    bit m_sv, m_rv;
    int m_sl, m_si, m_rc, m_rl, m_ri;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Level l starts at slot 2**l-1 and holds 2**l slots; DM space bounds all levels
    function automatic bit legal(input int l, input int i);
        int sig;
        sig = (2 ** l - 1) + i / 2;
        return (sig < 2 ** (l + 1) - 1) && (sig <= ((2 ** (IW + 2) - 2) / 3) - 1);
    endfunction

    function automatic bit model_ready();
        bit f;
        f = 1'b0;
        for (int k = 0; k < NO; k++) if (ms[k] == 0) f = 1'b1;
        return f && !wake_valid && !(m_sv && !sync_ready);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NO; k++) begin ms[k] = 0; ml[k] = 0; mi[k] = 0; mh[k] = 0; end
        m_pend = 0; m_sv = 0; m_sl = 0; m_si = 0;
        m_rv = 0; m_rc = 0; m_rl = 0; m_ri = 0;
    endtask

    task automatic set_resp(input int code, input int l, input int i);
        m_rv = 1'b1; m_rc = code; m_rl = l; m_ri = i;
    endtask

    // Advance the model by one cycle using the inputs currently driven
    task automatic model_step(output bit acc);
        bit hs, dup, lg, tmo_ok;
        int ws, ts, fs;
        acc = 1'b0;
        if (rst) begin
            model_clear();
            return;
        end
        acc = req_valid && model_ready();
        hs  = m_sv && sync_ready;
        lg  = legal(int'(req_level), int'(req_id));
        dup = 1'b0; ws = -1; ts = -1; fs = -1;
        for (int k = NO - 1; k >= 0; k--) begin
            if (ms[k] == 0) fs = k;
            if (ms[k] == 2 && cyc - mh[k] >= TMO) ts = k;
            if (ms[k] != 0 && ml[k] == int'(req_level) && mi[k] == int'(req_id)) dup = 1'b1;
            if (ms[k] == 2 && ml[k] == int'(wake_level) && mi[k] == int'(wake_id)) ws = k;
        end
        tmo_ok = (ts >= 0) && !wake_valid && !(acc && (!lg || dup));
        m_rv = 1'b0;
        if (hs) begin
            ms[m_pend] = 2; mh[m_pend] = cyc; m_sv = 1'b0;
        end
        if (acc) begin
            if (!lg) set_resp(int'(FS_SIG_ERR), int'(req_level), int'(req_id));
            else if (dup) set_resp(int'(FS_DUP_ERR), int'(req_level), int'(req_id));
            else begin
                ms[fs] = 1; ml[fs] = int'(req_level); mi[fs] = int'(req_id);
                m_pend = fs; m_sv = 1'b1; m_sl = int'(req_level); m_si = int'(req_id);
            end
        end
        if (wake_valid) begin
            if (ws >= 0) begin
                ms[ws] = 0;
                set_resp(wake_err ? int'(FS_NET_ERR) : int'(FS_OK), int'(wake_level), int'(wake_id));
            end else
                set_resp(int'(FS_UNEXP), int'(wake_level), int'(wake_id));
        end
        if (tmo_ok) begin
            ms[ts] = 0;
            set_resp(int'(FS_TIMEOUT), ml[ts], mi[ts]);
        end
    endtask

    // One cycle: check ready before the edge, then registered outputs after it
    task automatic tick();
        bit acc;
        #2;
        check("req_ready", req_ready_o, model_ready());
        model_step(acc);
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        check("sync_valid", sync_valid_o, m_sv);
        if (m_sv) begin
            check("sync_level", sync_level_o, m_sl);
            check("sync_id", sync_id_o, m_si);
        end
        check("resp_valid", resp_valid_o, m_rv);
        if (m_rv) begin
            check("resp_code", resp_code_o, m_rc);
            check("resp_level", resp_level_o, m_rl);
            check("resp_id", resp_id_o, m_ri);
        end
    endtask

    // Driver tasks
    task automatic idle();
        req_valid = 0; wake_valid = 0; wake_err = 0; sync_ready = 1;
    endtask

    task automatic rq(input int l, input int i);
        req_valid = 1; req_level = LW'(l); req_id = IW'(i);
    endtask

    task automatic wk(input int l, input int i, input bit e);
        wake_valid = 1; wake_level = LW'(l); wake_id = IW'(i); wake_err = e;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin idle(); tick(); end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sync_valid"}, sync_valid_o, 0);
        check({tag, "_sync_level"}, sync_level_o, 0);
        check({tag, "_sync_id"}, sync_id_o, 0);
        check({tag, "_resp_valid"}, resp_valid_o, 0);
        check({tag, "_resp_level"}, resp_level_o, 0);
        check({tag, "_resp_id"}, resp_id_o, 0);
        check({tag, "_resp_code"}, resp_code_o, 0);
    endtask

    initial begin
        rst = 1; req_level = 0; req_id = 0; wake_level = 0; wake_id = 0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_outputs_zero("reset");
        check("reset_ready", req_ready_o, 1);

        // Basic accept / issue / wake OK
        idle(); rq(1, 2); tick();
        idle(); tick();
        idle(); wk(1, 2, 0); tick();
        idle_ticks(2);

        // Illegal signatures (level 0 id 2, level 3 id 0)
        idle(); rq(0, 2); tick();
        idle(); rq(3, 0); tick();
        idle_ticks(2);

        // Fill the table, fifth request blocked, wake frees a slot, then a duplicate
        rq(0, 0); tick();
        rq(0, 1); tick();
        rq(1, 0); tick();
        rq(1, 1); tick();
        rq(1, 3); tick();
        rq(1, 3); tick();
        wk(0, 0, 0); tick();
        wake_valid = 0; tick();
        idle(); wk(0, 1, 1); tick();
        idle(); rq(1, 0); tick();
        idle_ticks(TMO + 4);

        // Sync stalled for five cycles; wake for the pending barrier is unexpected
        idle(); sync_ready = 0; rq(1, 2); tick();
        rq(2, 0); sync_ready = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) wk(1, 2, 0); else wake_valid = 0;
            tick();
        end
        idle(); tick();
        idle_ticks(TMO + 4);

        // Timeout with no wake, then a wake landing on the timeout cycle
        idle(); rq(2, 1); tick();
        idle_ticks(TMO + 3);
        idle(); rq(2, 0); tick();
        idle(); tick();
        idle_ticks(TMO - 1);
        idle(); wk(2, 0, 0); tick();
        idle_ticks(3);

        // Reset with three sent barriers and a stalled sync; later wakes unexpected
        rq(0, 0); tick();
        rq(0, 1); tick();
        rq(1, 1); tick();
        idle(); rq(2, 0); tick();
        idle(); sync_ready = 0; tick();
        rst = 1; tick();
        rst = 0;
        check_outputs_zero("midrst");
        idle(); wk(0, 0, 0); tick();
        idle(); wk(1, 1, 0); tick();
        idle_ticks(2);

        // Random traffic with requests held until accepted
        idle();
        for (int n = 0; n < 400; n++) begin
            int k;
            if (!req_valid || last_acc) begin
                req_valid = ($urandom_range(0, 1) == 1);
                req_level = LW'($urandom_range(0, 3));
                req_id    = IW'($urandom_range(0, 3));
            end
            sync_ready = ($urandom_range(0, 9) < 7);
            wake_valid = ($urandom_range(0, 3) == 0);
            wake_err   = ($urandom_range(0, 4) == 0);
            k = $urandom_range(0, NO - 1);
            if ($urandom_range(0, 3) != 0) begin
                wake_level = LW'(ml[k]); wake_id = IW'(mi[k]);
            end else begin
                wake_level = LW'($urandom_range(0, 3)); wake_id = IW'($urandom_range(0, 3));
            end
            tick();
        end
        idle_ticks(TMO + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
